multicycle_cpu: RTL

Parametrised multi-cycle successor to the single-cycle 16-bit core. It executes one instruction per 3–5 cycles through an explicit state machine. It fetches instructions and accesses data over req/ready handshake ports, so slow or wait-stated memories can sit behind it. Datapath width and PC width are parameters, and it adds a halt state and a sticky overflow flag. It is the top-level compute block; instruction and data memories sit outside it.

---
 rtl/multicycle_cpu.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cpu
// Brief    : 16-bit-ISA multi-cycle core with req/ready memory ports and halt.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_cpu #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] alu_out,
    output logic              retire,
    output logic              ovf,
    output logic              halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_ADDI = 4'd5;
    localparam logic [3:0] c_OP_LW   = 4'd6;
    localparam logic [3:0] c_OP_SW   = 4'd7;
    localparam logic [3:0] c_OP_BEQ  = 4'd8;
    localparam logic [3:0] c_OP_HALT = 4'd15;
    localparam int         c_MSB     = DATA_W - 1;

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_rf [8];
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [DATA_W-1:0]   r_op_d;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_load;
    logic                r_ovf;
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;

    logic [3:0]          w_opcode;
    logic [2:0]          w_rd;
    logic [2:0]          w_rs1;
    logic [2:0]          w_rs2;
    logic [DATA_W-1:0]   w_imm;
    logic [PC_W-1:0]     w_imm_pc;
    logic [DATA_W-1:0]   w_add;
    logic [DATA_W-1:0]   w_sub;
    logic [DATA_W-1:0]   w_addi;
    logic [DATA_W-1:0]   w_alu;
    logic                w_ovf_now;
    logic                w_is_alu;
    logic                w_is_mem;
    logic                w_imem_acc;
    logic                w_dmem_acc;
    logic                w_retire;
    logic                w_take_br;
    logic [PC_W-1:0]     w_pc_next;

    assign w_opcode   = r_ir[15:12];
    assign w_rd       = r_ir[11:9];
    assign w_rs1      = r_ir[8:6];
    assign w_rs2      = r_ir[5:3];
    assign w_imm      = DATA_W'($signed(r_ir[5:0]));
    assign w_imm_pc   = PC_W'($signed(r_ir[5:0]));
    assign w_add      = r_op_a + r_op_b;
    assign w_sub      = r_op_a - r_op_b;
    assign w_addi     = r_op_a + w_imm;
    assign w_is_alu   = (w_opcode <= c_OP_ADDI);
    assign w_is_mem   = (w_opcode == c_OP_LW) || (w_opcode == c_OP_SW);
    assign w_imem_acc = r_imem_req && imem_ready;
    assign w_dmem_acc = r_dmem_req && dmem_ready;
    assign w_take_br  = (r_state == S_EXEC) && (w_opcode == c_OP_BEQ) && (r_op_d == r_op_a);
    assign w_pc_next  = w_take_br ? (r_pc + PC_W'(1) + w_imm_pc) : (r_pc + PC_W'(1));

    // Memory ops reuse the ALU adder for the effective address.
    always_comb begin
        w_alu     = '0;
        w_ovf_now = 1'b0;
        case (w_opcode)
            c_OP_ADD: begin
                w_alu     = w_add;
                w_ovf_now = (r_op_a[c_MSB] == r_op_b[c_MSB]) && (w_add[c_MSB] != r_op_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_alu     = w_sub;
                w_ovf_now = (r_op_a[c_MSB] != r_op_b[c_MSB]) && (w_sub[c_MSB] != r_op_a[c_MSB]);
            end
            c_OP_AND: w_alu = r_op_a & r_op_b;
            c_OP_OR:  w_alu = r_op_a | r_op_b;
            c_OP_XOR: w_alu = r_op_a ^ r_op_b;
            c_OP_ADDI: begin
                w_alu     = w_addi;
                w_ovf_now = (r_op_a[c_MSB] == w_imm[c_MSB]) && (w_addi[c_MSB] != r_op_a[c_MSB]);
            end
            c_OP_LW, c_OP_SW: w_alu = w_addi;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (w_imem_acc) w_next = S_DECODE;
            S_DECODE: w_next = (w_opcode == c_OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_is_mem) begin
                    w_next = S_MEM;
                end else if (w_is_alu) begin
                    w_next = S_WB;
                end else begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                if (w_dmem_acc) begin
                    if (w_opcode == c_OP_LW) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Requests are registered from the next state so they rise one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_d     <= '0;
            r_alu      <= '0;
            r_load     <= '0;
            r_ovf      <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            r_state    <= w_next;
            r_imem_req <= (w_next == S_FETCH);
            r_dmem_req <= (w_next == S_MEM);
            r_dmem_we  <= (w_next == S_MEM) && (w_opcode == c_OP_SW);
            if (r_state == S_FETCH && w_imem_acc) r_ir <= imem_rdata;
            if (r_state == S_DECODE) begin
                r_op_a <= r_rf[w_rs1];
                r_op_b <= r_rf[w_rs2];
                r_op_d <= r_rf[w_rd];
            end
            if (r_state == S_EXEC) begin
                r_alu <= w_alu;
                if (w_ovf_now) r_ovf <= 1'b1;
            end
            if (r_state == S_MEM && w_dmem_acc) r_load <= dmem_rdata;
            if (r_state == S_WB && w_rd != 3'd0)
                r_rf[w_rd] <= (w_opcode == c_OP_LW) ? r_load : r_alu;
            if (w_retire) r_pc <= w_pc_next;
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_op_d;
    assign pc_out     = r_pc;
    assign alu_out    = r_alu;
    assign retire     = w_retire;
    assign ovf        = r_ovf;
    assign halted     = (r_state == S_HALT);

endmodule
`default_nettype wire
